// File: rtl/bist_controller.sv
// Scan-BIST sequencer: steps scan_en through shift/capture/flush, compacts
// scan_out into a signature register and reports a registered pass/fail.
module bist_controller #(
  parameter int                   CHAIN_LEN    = 8,
  parameter int                   NUM_PATTERNS = 16,
  parameter int                   SIG_WIDTH    = 8,
  parameter logic [SIG_WIDTH-1:0] POLY         = 8'h1D,
  parameter logic [SIG_WIDTH-1:0] GOLDEN_SIG   = 8'h00
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic                                scan_out,
  output logic                                scan_en,
  output logic                                busy,
  output logic                                done,
  output logic                                pass,
  output logic [SIG_WIDTH-1:0]                signature,
  output logic [$clog2(NUM_PATTERNS+1)-1:0]   pattern_cnt
);

  localparam int PCNT_W = $clog2(NUM_PATTERNS + 1);
  localparam int SCNT_W = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam logic [SCNT_W-1:0] SHIFT_LAST = SCNT_W'(CHAIN_LEN - 1);
  localparam logic [PCNT_W-1:0] PCNT_MAX   = PCNT_W'(NUM_PATTERNS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_CAPTURE,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t               r_state;
  logic [SCNT_W-1:0]    r_shift_cnt;
  logic [PCNT_W-1:0]    r_pattern_cnt;
  logic [SIG_WIDTH-1:0] r_signature;
  logic                 r_pass;
  logic                 r_scan_en;
  logic                 r_busy;
  logic                 r_done;

  state_t               w_state_next;
  logic [SCNT_W-1:0]    w_shift_cnt_next;
  logic [PCNT_W-1:0]    w_pattern_cnt_next;
  logic [PCNT_W-1:0]    w_pattern_cnt_inc;
  logic [SIG_WIDTH-1:0] w_signature_next;
  logic [SIG_WIDTH-1:0] w_sig_step;
  logic                 w_fb;
  logic                 w_pass_next;
  logic                 w_shift_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_shift_cnt   <= '0;
      r_pattern_cnt <= '0;
      r_signature   <= '0;
      r_pass        <= 1'b0;
      r_scan_en     <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_shift_cnt   <= w_shift_cnt_next;
      r_pattern_cnt <= w_pattern_cnt_next;
      r_signature   <= w_signature_next;
      r_pass        <= w_pass_next;
      // Outputs are decoded from the next state so they are true flops.
      r_scan_en     <= (w_state_next == S_SHIFT) || (w_state_next == S_FLUSH);
      r_busy        <= (w_state_next == S_SHIFT) || (w_state_next == S_CAPTURE) ||
                       (w_state_next == S_FLUSH);
      r_done        <= (w_state_next == S_DONE);
    end
  end

  always_comb begin
    w_state_next       = r_state;
    w_shift_cnt_next   = r_shift_cnt;
    w_pattern_cnt_next = r_pattern_cnt;
    w_signature_next   = r_signature;
    w_pass_next        = r_pass;
    w_shift_last       = (r_shift_cnt == SHIFT_LAST);
    w_fb               = r_signature[SIG_WIDTH-1] ^ scan_out;
    w_sig_step         = {r_signature[SIG_WIDTH-2:0], 1'b0} ^ (w_fb ? POLY : '0);
    w_pattern_cnt_inc  = (r_pattern_cnt < PCNT_MAX) ? r_pattern_cnt + PCNT_W'(1)
                                                    : r_pattern_cnt;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next       = S_SHIFT;
          w_shift_cnt_next   = '0;
          w_pattern_cnt_next = '0;
          w_signature_next   = '0;
          w_pass_next        = 1'b0;
        end
      end
      S_SHIFT: begin
        // The first load only flushes pre-test chain contents.
        if (r_pattern_cnt != '0) begin
          w_signature_next = w_sig_step;
        end
        if (w_shift_last) begin
          w_state_next     = S_CAPTURE;
          w_shift_cnt_next = '0;
        end else begin
          w_shift_cnt_next = r_shift_cnt + SCNT_W'(1);
        end
      end
      S_CAPTURE: begin
        w_pattern_cnt_next = w_pattern_cnt_inc;
        w_state_next       = (w_pattern_cnt_inc < PCNT_MAX) ? S_SHIFT : S_FLUSH;
      end
      S_FLUSH: begin
        w_signature_next = w_sig_step;
        if (w_shift_last) begin
          w_state_next     = S_DONE;
          w_shift_cnt_next = '0;
          w_pass_next      = (w_sig_step == GOLDEN_SIG);
        end else begin
          w_shift_cnt_next = r_shift_cnt + SCNT_W'(1);
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign scan_en     = r_scan_en;
  assign busy        = r_busy;
  assign done        = r_done;
  assign pass        = r_pass;
  assign signature   = r_signature;
  assign pattern_cnt = r_pattern_cnt;

endmodule

// File: tb/tb_bist_controller.sv
// Bench for bist_controller: cycle-indexed run model for the default instance
// plus literal checks on a minimal CHAIN_LEN=2 / NUM_PATTERNS=1 configuration.
module tb_bist_controller;

  localparam int CL    = 8;
  localparam int NP    = 16;
  localparam int LOADS = NP * (CL + 1);
  localparam int TOTAL = LOADS + CL;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       scan_out = 1'b0;
  logic       scan_en, busy, done, pass;
  logic [7:0] signature;
  logic [4:0] pattern_cnt;

  logic       m_start = 1'b0;
  logic       a_scan_en, a_busy, a_done, a_pass;
  logic [7:0] a_signature;
  logic [0:0] a_pattern_cnt;
  logic       b_scan_en, b_busy, b_done, b_pass;
  logic [7:0] b_signature;
  logic [0:0] b_pattern_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int n_busy   = 0;
  int n_done   = 0;
  int so_mode  = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  bist_controller dut (
    .clk(clk), .rst(rst), .start(start), .scan_out(scan_out),
    .scan_en(scan_en), .busy(busy), .done(done), .pass(pass),
    .signature(signature), .pattern_cnt(pattern_cnt)
  );

  bist_controller #(.CHAIN_LEN(2), .NUM_PATTERNS(1), .GOLDEN_SIG(8'h27)) dut_a (
    .clk(clk), .rst(rst), .start(m_start), .scan_out(1'b1),
    .scan_en(a_scan_en), .busy(a_busy), .done(a_done), .pass(a_pass),
    .signature(a_signature), .pattern_cnt(a_pattern_cnt)
  );

  bist_controller #(.CHAIN_LEN(2), .NUM_PATTERNS(1), .GOLDEN_SIG(8'h00)) dut_b (
    .clk(clk), .rst(rst), .start(m_start), .scan_out(1'b1),
    .scan_en(b_scan_en), .busy(b_busy), .done(b_done), .pass(b_pass),
    .signature(b_signature), .pattern_cnt(b_pattern_cnt)
  );

  // Run model: a run is a sequence of cycles k = 0..TOTAL, where cycle TOTAL is done.
  bit         m_active = 1'b0;
  int         m_k      = 0;
  logic [7:0] m_sig    = 8'h00;
  int         m_pcnt   = 0;
  bit         m_pass   = 1'b0;

  function automatic logic [7:0] sig_step(input logic [7:0] s, input logic b);
    logic fb;
    fb = s[7] ^ b;
    return {s[6:0], 1'b0} ^ (fb ? 8'h1D : 8'h00);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_active = 1'b0; m_sig = 8'h00; m_pcnt = 0; m_pass = 1'b0;
    end else if (!m_active) begin
      if (start) begin
        m_active = 1'b1; m_k = 0; m_sig = 8'h00; m_pcnt = 0; m_pass = 1'b0;
      end
    end else begin
      if (m_k < LOADS) begin
        if (m_k % (CL + 1) < CL) begin
          if (m_k / (CL + 1) > 0) m_sig = sig_step(m_sig, scan_out);
        end else begin
          m_pcnt = m_k / (CL + 1) + 1;
        end
      end else if (m_k < TOTAL) begin
        m_sig = sig_step(m_sig, scan_out);
        if (m_k == TOTAL - 1) m_pass = (m_sig == 8'h00);
      end else begin
        m_active = 1'b0;
      end
      m_k++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One negedge step: tally, compare the default DUT to the model, drive scan_out.
  task automatic tick();
    bit e_busy, e_done, e_scan_en;
    @(negedge clk);
    if (busy === 1'b1) n_busy++;
    if (done === 1'b1) n_done++;
    if (chk_en) begin
      e_busy    = m_active && (m_k < TOTAL);
      e_done    = m_active && (m_k == TOTAL);
      e_scan_en = e_busy && ((m_k >= LOADS) || (m_k % (CL + 1) < CL));
      check("scan_en", 32'(scan_en), 32'(e_scan_en));
      check("busy", 32'(busy), 32'(e_busy));
      check("done", 32'(done), 32'(e_done));
      check("pass", 32'(pass), 32'(m_pass));
      check("signature", 32'(signature), 32'(m_sig));
      check("pattern_cnt", 32'(pattern_cnt), 32'(m_pcnt));
    end
    case (so_mode)
      0:       scan_out = 1'b0;
      1:       scan_out = 1'b1;
      default: scan_out = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic wait_done(input int budget);
    int cyc = 0;
    while (done !== 1'b1 && cyc < budget) begin
      tick();
      cyc++;
    end
    check("done_timeout", 32'(done), 32'd1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base_busy, base_done;
    logic [5:0] a_se;
    logic [7:0] a_sig [6];
    repeat (3) tick();
    chk_en = 1'b1;
    check("rst_scan_en", 32'(scan_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_signature", 32'(signature), 32'd0);
    check("rst_pattern_cnt", 32'(pattern_cnt), 32'd0);
    rst = 1'b0;
    tick();

    // All-zero stream: signature stays 0 and the run passes.
    so_mode = 0; base_busy = n_busy; base_done = n_done;
    pulse_start();
    wait_done(400);
    check("zero_sig", 32'(signature), 32'h00);
    check("zero_pass", 32'(pass), 32'd1);
    check("zero_pcnt", 32'(pattern_cnt), 32'd16);
    tick();
    check("zero_busy_len", 32'(n_busy - base_busy), 32'd152);
    check("zero_done_cnt", 32'(n_done - base_done), 32'd1);

    // Random stream with start re-pulsed at busy cycles 3 and 100.
    so_mode = 2; base_busy = n_busy; base_done = n_done;
    pulse_start();
    repeat (3) tick();
    pulse_start();
    repeat (96) tick();
    pulse_start();
    wait_done(400);
    tick();
    check("repulse_busy_len", 32'(n_busy - base_busy), 32'd152);
    check("repulse_done_cnt", 32'(n_done - base_done), 32'd1);

    // Reset at busy cycle 50 aborts the run without a done pulse.
    base_done = n_done;
    pulse_start();
    repeat (50) tick();
    rst = 1'b1;
    tick();
    check("abort_scan_en", 32'(scan_en), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_signature", 32'(signature), 32'd0);
    check("abort_pattern_cnt", 32'(pattern_cnt), 32'd0);
    rst = 1'b0;
    repeat (200) tick();
    check("abort_no_done", 32'(n_done - base_done), 32'd0);

    // start held high: back-to-back runs separated by one idle cycle.
    base_busy = n_busy; base_done = n_done;
    start = 1'b1;
    wait_done(400);
    tick();
    check("cont_idle_gap", 32'(busy), 32'd0);
    tick();
    check("cont_restart", 32'(busy), 32'd1);
    wait_done(400);
    start = 1'b0;
    tick();
    check("cont_done_cnt", 32'(n_done - base_done), 32'd2);
    check("cont_busy_len", 32'(n_busy - base_busy), 32'd304);

    // Random runs with random idle gaps and stream patterns.
    for (int r = 0; r < 4; r++) begin
      so_mode = (r == 1) ? 1 : 2;
      repeat ($urandom_range(0, 5)) tick();
      pulse_start();
      wait_done(400);
      tick();
    end

    // Minimal configuration with scan_out tied high.
    m_start = 1'b1;
    tick();
    m_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) tick();
      a_se[i]  = a_scan_en;
      a_sig[i] = a_signature;
    end
    check("min_scan_en_seq", 32'(a_se), 32'(6'b011011));
    check("min_sig_uncompacted", 32'(a_sig[3]), 32'h00);
    check("min_sig_flush1", 32'(a_sig[4]), 32'h1D);
    check("min_sig_final", 32'(a_sig[5]), 32'h27);
    check("min_done", 32'(a_done), 32'd1);
    check("min_pcnt", 32'(a_pattern_cnt), 32'd1);
    check("min_pass_golden27", 32'(a_pass), 32'd1);
    check("min_pass_golden00", 32'(b_pass), 32'd0);
    check("min_b_sig_final", 32'(b_signature), 32'h27);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bist_controller.md
Name: bist_controller

Overview:
- Sequencer for the scan-based BIST datapath: the LFSR-fed scan chain with scan_en, scan_in and scan_out.
- Drives scan_en through repeated shift/capture cycles and compacts the serial scan_out stream into a signature register.
- Compares the final signature against a golden value and reports pass/fail.
- Sits between the test-start logic and the BIST datapath; it does not drive scan_in (the datapath's LFSR does).

Parameters:
- CHAIN_LEN, 8, scan chain length; number of shift cycles per pattern.
- NUM_PATTERNS, 16, number of capture cycles per test run.
- SIG_WIDTH, 8, signature register width.
- POLY, 8'h1D, signature feedback polynomial mask (bit 0 must be set).
- GOLDEN_SIG, 8'h00, expected final signature.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a test run; sampled only in IDLE.
- scan_out  input  1  serial output of the scan chain.
- scan_en  output  1  1 = shift, 0 = capture/hold; drives the datapath.
- busy  output  1  high in SHIFT, CAPTURE and FLUSH.
- done  output  1  one-cycle pulse when the run completes.
- pass  output  1  registered result (signature == GOLDEN_SIG); valid from done, held until the next start.
- signature  output  SIG_WIDTH  current signature register.
- pattern_cnt  output  $clog2(NUM_PATTERNS+1)  number of captures completed.

Behaviour:
- Reset (rst=1 at a clock edge) forces:
  - state=IDLE, scan_en=0, busy=0, done=0, pass=0, signature=0, pattern_cnt=0, shift counter=0.
  - This applies from any state, including mid-run; an aborted run never pulses done.
- States: IDLE, SHIFT, CAPTURE, FLUSH, DONE.
- IDLE:
  - scan_en=0, busy=0.
  - start=1 moves to SHIFT next cycle and clears signature, pattern_cnt, shift counter and pass in that same edge.
- SHIFT:
  - scan_en=1 for exactly CHAIN_LEN consecutive cycles, then CAPTURE.
  - Compaction is enabled only when pattern_cnt>0. The first load shifts out pre-test chain contents, which are not compacted.
- CAPTURE:
  - scan_en=0 for exactly 1 cycle; pattern_cnt increments.
  - Next state is SHIFT if the new pattern_cnt < NUM_PATTERNS, otherwise FLUSH.
- FLUSH:
  - scan_en=1 for exactly CHAIN_LEN cycles, compaction enabled, then DONE.
- DONE:
  - One cycle: done=1, busy=0, scan_en=0, pass=(signature==GOLDEN_SIG). The compare uses the final signature, already complete on entry.
  - Next state is IDLE.
- Compaction step, applied on each compacting shift cycle:
  - fb = signature[SIG_WIDTH-1] ^ scan_out.
  - signature_next = {signature[SIG_WIDTH-2:0],1'b0} ^ (fb ? POLY : 0).
- Compacted bit count = NUM_PATTERNS*CHAIN_LEN.
- Busy duration from the first SHIFT cycle to the last FLUSH cycle = NUM_PATTERNS*(CHAIN_LEN+1)+CHAIN_LEN cycles (152 at defaults). done is asserted on the cycle after the last FLUSH cycle.
- start while busy or in DONE: ignored; no restart, no counter effect.
- start held high continuously: a new run begins on the first IDLE cycle after DONE.
- scan_en, busy, done and pass are registered; there are no combinational paths from inputs.
- The shift counter wraps to 0 on each SHIFT→CAPTURE and FLUSH→DONE transition.
- pattern_cnt saturates at NUM_PATTERNS and holds until the next start.

Test Plan:
- Reset mid-run:
  - Defaults, start pulse, rst=1 at busy cycle 50 → next edge scan_en=0, busy=0, signature=0, pattern_cnt=0.
  - No done pulse afterwards until a new start.
- scan_en sequence:
  - Defaults, one start pulse → scan_en=1 for 8 cycles, then 0 for 1 cycle, repeated 16 times, then 1 for 8 cycles.
  - busy high for exactly 152 cycles; done pulses once on the cycle after busy falls; pattern_cnt=16.
- All-zero stream:
  - Defaults, scan_out tied 0 → signature=8'h00 at done, pass=1.
- Minimal run, scan_out tied 1:
  - CHAIN_LEN=2, NUM_PATTERNS=1 → scan_en pattern 1,1,0,1,1.
  - The first two shift cycles are not compacted; the signature after the flush cycles is 8'h1D then 8'h27.
  - With GOLDEN_SIG=8'h27 → pass=1; with GOLDEN_SIG=8'h00 → pass=0.
- start ignored while busy:
  - Defaults, start re-pulsed at busy cycles 3 and 100 → run length still 152, single done pulse, pattern_cnt never exceeds 16.
- Continuous start:
  - Defaults, start held high → done pulse, one IDLE cycle (signature cleared on that edge), new 152-cycle busy window.
  - pass from the previous run holds through DONE and is cleared when the new run starts.
